// File: rtl/our_dac_spi_tx_if.sv
// Handshake, status and DAC pin bundle between the our_dac register block
// and the SPI transmitter. The master side is the register block / board,
// the slave side is the transmitter itself.
interface our_dac_spi_tx_if #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic                  enable;
  logic                  ldac_auto;
  logic [LW-1:0]         fifo_level;
  logic                  busy;
  logic                  frame_done;
  logic                  dac_sync_n;
  logic                  dac_sclk;
  logic                  dac_sdin;
  logic                  dac_ldac_n;

  modport master (
    output s_data, s_valid, enable, ldac_auto,
    input  s_ready, fifo_level, busy, frame_done,
    input  dac_sync_n, dac_sclk, dac_sdin, dac_ldac_n
  );

  modport slave (
    input  s_data, s_valid, enable, ldac_auto,
    output s_ready, fifo_level, busy, frame_done,
    output dac_sync_n, dac_sclk, dac_sdin, dac_ldac_n
  );
endinterface

// File: rtl/our_dac_spi_tx.sv
// SPI transmitter for the our_dac block: buffers DAC codes in a small FIFO
// and shifts each one out MSB-first on SYNC_N/SCLK/SDIN, with an optional
// LDAC_N load strobe after each frame. All DAC pins come straight from flops.
module our_dac_spi_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2,
  parameter int GAP        = 2
) (
  input logic            ACLK,
  input logic            ARESET,
  our_dac_spi_tx_if.slave bus
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;
  localparam int BW    = $clog2(DATA_WIDTH) + 1;
  localparam int VW    = $clog2(CLK_DIV) + 1;
  localparam int TMAX1 = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int TMAX2 = (GAP > 2) ? GAP : 2;
  localparam int TMAX  = (TMAX1 > TMAX2) ? TMAX1 : TMAX2;
  localparam int TW    = $clog2(TMAX) + 1;

  localparam logic [LW-1:0] FULL       = LW'(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_WIDTH - 1);
  localparam logic [VW-1:0] DIV_LAST   = VW'(CLK_DIV - 1);
  localparam logic [TW-1:0] SETUP_LAST = TW'(CS_SETUP - 1);
  localparam logic [TW-1:0] HOLD_LAST  = TW'(CS_HOLD - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP - 1);
  localparam logic [TW-1:0] LDAC_LAST  = TW'(1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD, ST_LDAC, ST_GAP
  } state_t;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [LW-1:0]         level;
  logic                  push, pop, ready;

  state_t                state, state_n;
  logic [TW-1:0]         tmr, tmr_n;
  logic [VW-1:0]         div_cnt, div_n;
  logic [BW-1:0]         bit_cnt, bit_n;
  logic [DATA_WIDTH-1:0] shreg, shreg_n;
  logic                  sync_q, sync_n_n;
  logic                  sclk_q, sclk_n;
  logic                  sdin_q, sdin_n;
  logic                  ldac_q, ldac_n_n;
  logic                  done_q, done_n;

  // A full FIFO refuses data even while the head is being popped.
  assign ready = (level != FULL);
  assign push  = bus.s_valid && ready;

  // FIFO storage has no reset; only the pointers and level define its contents.
  always_ff @(posedge ACLK) begin
    if (push) mem[wr_ptr] <= bus.s_data;
  end

  // FIFO pointers and fill level; a simultaneous push and pop leaves the level alone.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Frame sequencer: decides next state, counters and the next value of every DAC pin.
  always_comb begin
    state_n  = state;
    tmr_n    = tmr;
    div_n    = div_cnt;
    bit_n    = bit_cnt;
    shreg_n  = shreg;
    sync_n_n = sync_q;
    sclk_n   = sclk_q;
    sdin_n   = sdin_q;
    ldac_n_n = 1'b1;
    done_n   = 1'b0;
    pop      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.enable && level != '0) begin
          pop      = 1'b1;
          shreg_n  = mem[rd_ptr];
          sdin_n   = mem[rd_ptr][DATA_WIDTH-1];
          sync_n_n = 1'b0;
          tmr_n    = '0;
          state_n  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tmr == SETUP_LAST) begin
          sclk_n  = 1'b0;
          div_n   = '0;
          bit_n   = '0;
          state_n = ST_SHIFT;
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (div_cnt != DIV_LAST) begin
          div_n = div_cnt + 1'b1;
        end else begin
          div_n = '0;
          if (!sclk_q) begin
            sclk_n = 1'b1;
            if (bit_cnt != LAST_BIT) begin
              sdin_n  = shreg[DATA_WIDTH-2];
              shreg_n = shreg << 1;
            end
          end else if (bit_cnt == LAST_BIT) begin
            tmr_n   = '0;
            state_n = ST_HOLD;
          end else begin
            sclk_n = 1'b0;
            bit_n  = bit_cnt + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (tmr == HOLD_LAST) begin
          sync_n_n = 1'b1;
          done_n   = 1'b1;
          tmr_n    = '0;
          state_n  = bus.ldac_auto ? ST_LDAC : ST_GAP;
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end
      ST_LDAC: begin
        ldac_n_n = 1'b0;
        if (tmr == LDAC_LAST) begin
          tmr_n   = '0;
          state_n = ST_GAP;
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end
      ST_GAP: begin
        if (tmr == GAP_LAST) state_n = ST_IDLE;
        else                 tmr_n   = tmr + 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Sequencer state and registered DAC pins; reset abandons any frame in flight.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state   <= ST_IDLE;
      tmr     <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      sync_q  <= 1'b1;
      sclk_q  <= 1'b1;
      sdin_q  <= 1'b0;
      ldac_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      tmr     <= tmr_n;
      div_cnt <= div_n;
      bit_cnt <= bit_n;
      shreg   <= shreg_n;
      sync_q  <= sync_n_n;
      sclk_q  <= sclk_n;
      sdin_q  <= sdin_n;
      ldac_q  <= ldac_n_n;
      done_q  <= done_n;
    end
  end

  assign bus.s_ready    = ready;
  assign bus.fifo_level = level;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.frame_done = done_q;
  assign bus.dac_sync_n = sync_q;
  assign bus.dac_sclk   = sclk_q;
  assign bus.dac_sdin   = sdin_q;
  assign bus.dac_ldac_n = ldac_q;
endmodule

// File: tb/tb_our_dac_spi_tx.sv
// Self-checking bench for our_dac_spi_tx. A negedge monitor decodes SPI
// frames like the DAC would; tasks compare them against codes accepted by
// the handshake and against frame timing computed from the block's rules.
module tb_our_dac_spi_tx;
  localparam int DW = 16, DIV = 4, DEPTH = 4, SETUP = 2, HOLD = 2, GAPC = 2;
  localparam int LOW_LEN = SETUP + 2 * DIV * DW + HOLD;
  localparam int PERIOD  = 1 + LOW_LEN + GAPC;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  our_dac_spi_tx_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

  our_dac_spi_tx #(.DATA_WIDTH(DW), .CLK_DIV(DIV), .FIFO_DEPTH(DEPTH),
                   .CS_SETUP(SETUP), .CS_HOLD(HOLD), .GAP(GAPC)) dut (
    .ACLK(clk), .ARESET(rst), .bus(bus));

  always #5 clk = ~clk;

  // Monitor state: decoded frames and event cycle stamps.
  int          cyc = 0;
  logic        prev_sync = 1'b1, prev_sclk = 1'b1, prev_ldac = 1'b1;
  logic [15:0] shift_bits = '0;
  int          nbits = 0, low_cnt = 0, ldac_cnt = 0, sclk_edges = 0;
  logic [15:0] rx_q[$];
  int          nbits_q[$], low_q[$], fall_q[$], rise_q[$], done_q[$];
  int          lfall_q[$], llen_q[$];
  logic [15:0] exp_q[$];

  // Decode the SPI pins as the DAC sees them, one sample per clock cycle.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      nbits = 0; low_cnt = 0; ldac_cnt = 0; sclk_edges = 0;
    end else begin
      if (prev_sync && !bus.dac_sync_n) begin
        fall_q.push_back(cyc); nbits = 0; low_cnt = 0; sclk_edges = 0;
      end
      if (!bus.dac_sync_n) begin
        low_cnt++;
        if (prev_sclk != bus.dac_sclk) sclk_edges++;
        if (prev_sclk && !bus.dac_sclk) begin
          shift_bits = {shift_bits[14:0], bus.dac_sdin};
          nbits++;
        end
      end
      if (!prev_sync && bus.dac_sync_n) begin
        rx_q.push_back(shift_bits); nbits_q.push_back(nbits);
        low_q.push_back(low_cnt);   rise_q.push_back(cyc);
      end
      if (bus.frame_done) done_q.push_back(cyc);
      if (prev_ldac && !bus.dac_ldac_n) lfall_q.push_back(cyc);
      if (!bus.dac_ldac_n) ldac_cnt++;
      if (!prev_ldac && bus.dac_ldac_n) begin
        llen_q.push_back(ldac_cnt); ldac_cnt = 0;
      end
    end
    prev_sync = bus.dac_sync_n;
    prev_sclk = bus.dac_sclk;
    prev_ldac = bus.dac_ldac_n;
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic clear_mon();
    rx_q.delete(); nbits_q.delete(); low_q.delete(); fall_q.delete();
    rise_q.delete(); done_q.delete(); lfall_q.delete(); llen_q.delete();
    exp_q.delete();
  endtask

  // Offer one code and hold it until the handshake takes it.
  task automatic push(input logic [15:0] code, output bit ok);
    bus.s_data = code; bus.s_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      if (bus.s_ready) ok = 1'b1;
      tick();
    end
    bus.s_valid = 1'b0;
    bus.s_data  = 16'($urandom);
    if (ok) exp_q.push_back(code);
  endtask

  task automatic wait_frames(input int n, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      if (rx_q.size() >= n) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic settle();
    int i;
    i = 0;
    while (bus.busy && i < 1000) begin tick(); i++; end
    tick(); tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("[TB] FAIL settle: busy=%0b required 0", bus.busy);
    end
    clear_mon();
  endtask

  task automatic test_reset();
    #2 rst = 1'b1; #1;
    checks += 8;
    if (bus.dac_sync_n !== 1'b1) begin errors++; $display("[TB] FAIL rst_sync: %b vs 1", bus.dac_sync_n); end
    if (bus.dac_sclk !== 1'b1)   begin errors++; $display("[TB] FAIL rst_sclk: %b vs 1", bus.dac_sclk); end
    if (bus.dac_sdin !== 1'b0)   begin errors++; $display("[TB] FAIL rst_sdin: %b vs 0", bus.dac_sdin); end
    if (bus.dac_ldac_n !== 1'b1) begin errors++; $display("[TB] FAIL rst_ldac: %b vs 1", bus.dac_ldac_n); end
    if (bus.busy !== 1'b0)       begin errors++; $display("[TB] FAIL rst_busy: %b vs 0", bus.busy); end
    if (bus.frame_done !== 1'b0) begin errors++; $display("[TB] FAIL rst_done: %b vs 0", bus.frame_done); end
    if (bus.fifo_level !== 3'd0) begin errors++; $display("[TB] FAIL rst_level: %0d vs 0", bus.fifo_level); end
    if (bus.s_ready !== 1'b1)    begin errors++; $display("[TB] FAIL rst_ready: %b vs 1", bus.s_ready); end
    tick(); tick();
    rst = 1'b0;
    tick();
    clear_mon();
  endtask

  task automatic test_single_frame();
    bit ok;
    bus.ldac_auto = 1'b0; bus.enable = 1'b1;
    push(16'hA5C3, ok);
    checks += 2;
    if (!ok) begin errors++; $display("[TB] FAIL single_push: not accepted"); end
    if (bus.fifo_level !== 3'd1) begin errors++; $display("[TB] FAIL single_level1: %0d vs 1", bus.fifo_level); end
    wait_frames(1, 400, ok);
    checks++;
    if (!ok) begin
      errors++; $display("[TB] FAIL single_timeout: 0 frames vs 1");
    end else begin
      checks += 6;
      if (rx_q[0] !== 16'hA5C3) begin errors++; $display("[TB] FAIL single_code: %h vs a5c3", rx_q[0]); end
      if (nbits_q[0] != DW)     begin errors++; $display("[TB] FAIL single_bits: %0d vs %0d", nbits_q[0], DW); end
      if (low_q[0] != LOW_LEN)  begin errors++; $display("[TB] FAIL single_low: %0d vs %0d", low_q[0], LOW_LEN); end
      if (bus.fifo_level !== 3'd0) begin errors++; $display("[TB] FAIL single_level0: %0d vs 0", bus.fifo_level); end
      if (lfall_q.size() != 0)  begin errors++; $display("[TB] FAIL single_noldac: %0d pulses vs 0", lfall_q.size()); end
      if (done_q.size() != 1 || done_q[0] != rise_q[0]) begin
        errors++; $display("[TB] FAIL single_done: %0d pulses vs 1 at sync rise", done_q.size());
      end
    end
  endtask

  task automatic test_fifo_full();
    bit ok;
    bus.enable = 1'b0;
    for (int i = 0; i < DEPTH; i++) push(16'($urandom), ok);
    checks += 3;
    if (exp_q.size() != DEPTH)     begin errors++; $display("[TB] FAIL full_accepted: %0d vs %0d", exp_q.size(), DEPTH); end
    if (bus.fifo_level !== 3'd4)   begin errors++; $display("[TB] FAIL full_level: %0d vs 4", bus.fifo_level); end
    if (bus.s_ready !== 1'b0)      begin errors++; $display("[TB] FAIL full_ready: %b vs 0", bus.s_ready); end
    bus.s_data = 16'($urandom); bus.s_valid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checks += 3;
    if (bus.fifo_level !== 3'd4)   begin errors++; $display("[TB] FAIL full_held_level: %0d vs 4", bus.fifo_level); end
    if (fall_q.size() != 0)        begin errors++; $display("[TB] FAIL full_noframe: %0d vs 0", fall_q.size()); end
    if (bus.busy !== 1'b0)         begin errors++; $display("[TB] FAIL full_busy: %b vs 0", bus.busy); end
  endtask

  task automatic test_push_during_pop();
    bit ok;
    logic [15:0] c5;
    c5 = bus.s_data;
    bus.enable = 1'b1;
    checks++;
    if (bus.s_ready !== 1'b0) begin errors++; $display("[TB] FAIL pop_cycle_ready: %b vs 0", bus.s_ready); end
    tick();
    checks += 2;
    if (bus.fifo_level !== 3'd3) begin errors++; $display("[TB] FAIL after_pop_level: %0d vs 3", bus.fifo_level); end
    if (bus.s_ready !== 1'b1)    begin errors++; $display("[TB] FAIL after_pop_ready: %b vs 1", bus.s_ready); end
    tick();
    checks++;
    if (bus.fifo_level !== 3'd4) begin errors++; $display("[TB] FAIL repush_level: %0d vs 4", bus.fifo_level); end
    bus.s_valid = 1'b0;
    exp_q.push_back(c5);
    wait_frames(5, 2000, ok);
    checks++;
    if (!ok) begin
      errors++; $display("[TB] FAIL order_timeout: %0d frames vs 5", rx_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (rx_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL order_code%0d: %h vs %h", i, rx_q[i], exp_q[i]); end
      end
      for (int i = 0; i < 4; i++) begin
        checks += 2;
        if (fall_q[i+1] - fall_q[i] != PERIOD) begin
          errors++; $display("[TB] FAIL order_period%0d: %0d vs %0d", i, fall_q[i+1] - fall_q[i], PERIOD);
        end
        if (fall_q[i+1] - rise_q[i] < GAPC) begin
          errors++; $display("[TB] FAIL order_gap%0d: %0d vs >=%0d", i, fall_q[i+1] - rise_q[i], GAPC);
        end
      end
    end
  endtask

  task automatic test_ldac();
    bit ok;
    bus.ldac_auto = 1'b1; bus.enable = 1'b1;
    push(16'h0001, ok);
    push(16'($urandom), ok);
    wait_frames(2, 800, ok);
    tick(); tick(); tick(); tick();
    checks++;
    if (!ok) begin
      errors++; $display("[TB] FAIL ldac_timeout: %0d frames vs 2", rx_q.size());
    end else begin
      checks += 5;
      if (rx_q[0] !== 16'h0001 || rx_q[1] !== exp_q[1]) begin
        errors++; $display("[TB] FAIL ldac_codes: %h %h vs 0001 %h", rx_q[0], rx_q[1], exp_q[1]);
      end
      if (llen_q.size() != 2) begin
        errors++; $display("[TB] FAIL ldac_count: %0d vs 2", llen_q.size());
      end else if (llen_q[0] != 2 || llen_q[1] != 2) begin
        errors++; $display("[TB] FAIL ldac_width: %0d %0d vs 2 2", llen_q[0], llen_q[1]);
      end
      if (lfall_q.size() < 1 || lfall_q[0] - rise_q[0] != 1) begin
        errors++; $display("[TB] FAIL ldac_start: offset %0d vs 1", lfall_q.size() ? lfall_q[0] - rise_q[0] : -1);
      end
      if (fall_q[1] - fall_q[0] != PERIOD + 2) begin
        errors++; $display("[TB] FAIL ldac_period: %0d vs %0d", fall_q[1] - fall_q[0], PERIOD + 2);
      end
      if (done_q.size() != 2) begin
        errors++; $display("[TB] FAIL ldac_done: %0d vs 2", done_q.size());
      end
    end
    bus.ldac_auto = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int i;
    bus.enable = 1'b0;
    for (int k = 0; k < DEPTH; k++) push(16'($urandom), ok);
    bus.enable = 1'b1;
    i = 0;
    while (!(fall_q.size() == 1 && sclk_edges >= 7) && i < 400) begin tick(); i++; end
    checks++;
    if (sclk_edges != 7) begin errors++; $display("[TB] FAIL rmid_edge: %0d vs 7", sclk_edges); end
    rst = 1'b1; #1;
    checks += 6;
    if (bus.dac_sync_n !== 1'b1) begin errors++; $display("[TB] FAIL rmid_sync: %b vs 1", bus.dac_sync_n); end
    if (bus.dac_sclk !== 1'b1)   begin errors++; $display("[TB] FAIL rmid_sclk: %b vs 1", bus.dac_sclk); end
    if (bus.dac_sdin !== 1'b0)   begin errors++; $display("[TB] FAIL rmid_sdin: %b vs 0", bus.dac_sdin); end
    if (bus.busy !== 1'b0)       begin errors++; $display("[TB] FAIL rmid_busy: %b vs 0", bus.busy); end
    if (bus.fifo_level !== 3'd0) begin errors++; $display("[TB] FAIL rmid_level: %0d vs 0", bus.fifo_level); end
    if (bus.frame_done !== 1'b0) begin errors++; $display("[TB] FAIL rmid_done: %b vs 0", bus.frame_done); end
    tick(); tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    checks += 2;
    if (rx_q.size() != 0)   begin errors++; $display("[TB] FAIL rmid_noframe: %0d vs 0", rx_q.size()); end
    if (done_q.size() != 0) begin errors++; $display("[TB] FAIL rmid_nodone: %0d vs 0", done_q.size()); end
    clear_mon();
    push(16'h1234, ok);
    wait_frames(1, 400, ok);
    checks++;
    if (!ok || rx_q[0] !== 16'h1234 || nbits_q[0] != DW) begin
      errors++; $display("[TB] FAIL rmid_clean: %h vs 1234", ok ? rx_q[0] : 16'h0);
    end
  endtask

  task automatic test_enable_drop();
    bit ok;
    int i;
    logic [15:0] a, b;
    a = 16'($urandom); b = 16'($urandom);
    bus.enable = 1'b1;
    push(a, ok);
    push(b, ok);
    i = 0;
    while (!(fall_q.size() == 1 && sclk_edges >= 5) && i < 400) begin tick(); i++; end
    bus.enable = 1'b0;
    wait_frames(1, 400, ok);
    checks++;
    if (!ok || rx_q[0] !== a || nbits_q[0] != DW) begin
      errors++; $display("[TB] FAIL endrop_first: %h vs %h", ok ? rx_q[0] : 16'h0, a);
    end
    for (int k = 0; k < 300; k++) tick();
    checks += 2;
    if (fall_q.size() != 1)      begin errors++; $display("[TB] FAIL endrop_nostart: %0d frames vs 1", fall_q.size()); end
    if (bus.fifo_level !== 3'd1) begin errors++; $display("[TB] FAIL endrop_level: %0d vs 1", bus.fifo_level); end
    bus.enable = 1'b1;
    wait_frames(2, 400, ok);
    checks++;
    if (!ok || rx_q[1] !== b) begin
      errors++; $display("[TB] FAIL endrop_second: %h vs %h", ok ? rx_q[1] : 16'h0, b);
    end
  endtask

  task automatic test_back_to_back();
    bit ok, ldac;
    int per;
    ldac = 1'($urandom_range(0, 1));
    per  = PERIOD + (ldac ? 2 : 0);
    bus.ldac_auto = ldac; bus.enable = 1'b1;
    for (int i = 0; i < 6; i++) push(16'($urandom), ok);
    wait_frames(6, 3000, ok);
    for (int k = 0; k < 6; k++) tick();
    checks++;
    if (!ok) begin
      errors++; $display("[TB] FAIL b2b_timeout: %0d frames vs 6", rx_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (rx_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL b2b_code%0d: %h vs %h", i, rx_q[i], exp_q[i]); end
      end
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (fall_q[i+1] - fall_q[i] != per) begin
          errors++; $display("[TB] FAIL b2b_period%0d: %0d vs %0d", i, fall_q[i+1] - fall_q[i], per);
        end
      end
      checks++;
      if (llen_q.size() != (ldac ? 6 : 0)) begin
        errors++; $display("[TB] FAIL b2b_ldac: %0d pulses vs %0d", llen_q.size(), ldac ? 6 : 0);
      end
    end
    bus.ldac_auto = 1'b0;
  endtask

  // Run every scenario in order, then report.
  initial begin
    bus.s_data = '0; bus.s_valid = 1'b0; bus.enable = 1'b0; bus.ldac_auto = 1'b0;
    test_reset();
    test_single_frame();    settle();
    test_fifo_full();
    test_push_during_pop(); settle();
    test_ldac();            settle();
    test_reset_mid_frame(); settle();
    test_enable_drop();     settle();
    test_back_to_back();    settle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end
endmodule
